// File: rtl/dtw_result_serializer.sv
// dtw_result_serializer: round-robin collector of per-core DTW results that
// serialises each captured result as three 32-bit AXI-Stream words
// (header, min cost, position), grouping results into packets via TLAST.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for enable and a valid core; grants one core
//   W0    | presenting header {core_idx, 8'h00, qid}
//   W1    | presenting minimum DTW cost
//   W2    | presenting match position; packet may close here (TLAST)
module dtw_result_serializer #(
  parameter int NUM_CORES            = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int QID_WIDTH            = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              enable,
  input  logic [15:0]                       batch_len,
  input  logic [NUM_CORES-1:0]              res_valid,
  output logic [NUM_CORES-1:0]              res_ready,
  input  logic [32*NUM_CORES-1:0]           res_minval,
  input  logic [32*NUM_CORES-1:0]           res_position,
  input  logic [QID_WIDTH*NUM_CORES-1:0]    res_qid,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic [31:0]                       results_sent
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [7:0]         core_q, core_d;
  logic [15:0]        qid_q, qid_d;
  logic [31:0]        minval_q, minval_d;
  logic [31:0]        pos_q, pos_d;
  logic [15:0]        batch_cnt_q, batch_cnt_d;
  logic [31:0]        results_sent_q, results_sent_d;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic               hs;
  logic               last_in_pkt;

  // Round-robin search: first valid core after the previously granted one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (cand == IDX_W'(NUM_CORES - 1)) cand = '0;
      else                               cand = cand + 1'b1;
      if (!grant_found && res_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A lowered batch_len (below the count) also closes the packet, hence >=.
  assign last_in_pkt = (batch_len == 16'd0) ||
                       (({1'b0, batch_cnt_q} + 17'd1) >= {1'b0, batch_len});
  assign hs          = M_AXIS_TVALID && M_AXIS_TREADY;

  // Next-state, capture and counter logic.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    core_d         = core_q;
    qid_d          = qid_q;
    minval_d       = minval_q;
    pos_d          = pos_q;
    batch_cnt_d    = batch_cnt_q;
    results_sent_d = results_sent_q;
    res_ready      = '0;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          batch_cnt_d = '0;
        end else if (grant_found && M_AXIS_ARESETN) begin
          res_ready[grant_idx] = 1'b1;
          last_grant_d = grant_idx;
          core_d       = 8'(grant_idx);
          qid_d        = 16'(res_qid[QID_WIDTH*grant_idx +: QID_WIDTH]);
          minval_d     = res_minval[32*grant_idx +: 32];
          pos_d        = res_position[32*grant_idx +: 32];
          state_d      = W0;
        end
      end
      W0: if (hs) state_d = W1;
      W1: if (hs) state_d = W2;
      W2: begin
        if (hs) begin
          state_d        = IDLE;
          results_sent_d = results_sent_q + 32'd1;
          batch_cnt_d    = last_in_pkt ? 16'd0 : batch_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream outputs are decoded from the state; IDLE drives zero data.
  always_comb begin
    M_AXIS_TDATA = '0;
    case (state_q)
      W0:      M_AXIS_TDATA = C_M_AXIS_TDATA_WIDTH'({core_q, 8'h00, qid_q});
      W1:      M_AXIS_TDATA = C_M_AXIS_TDATA_WIDTH'(minval_q);
      W2:      M_AXIS_TDATA = C_M_AXIS_TDATA_WIDTH'(pos_q);
      default: M_AXIS_TDATA = '0;
    endcase
  end

  assign M_AXIS_TVALID = (state_q != IDLE);
  assign M_AXIS_TLAST  = (state_q == W2) && last_in_pkt;
  assign M_AXIS_TSTRB  = '1;
  assign busy          = (state_q != IDLE);
  assign results_sent  = results_sent_q;

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q        <= IDLE;
      last_grant_q   <= IDX_W'(NUM_CORES - 1);
      core_q         <= '0;
      qid_q          <= '0;
      minval_q       <= '0;
      pos_q          <= '0;
      batch_cnt_q    <= '0;
      results_sent_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      core_q         <= core_d;
      qid_q          <= qid_d;
      minval_q       <= minval_d;
      pos_q          <= pos_d;
      batch_cnt_q    <= batch_cnt_d;
      results_sent_q <= results_sent_d;
    end
  end

endmodule

// File: tb/tb_dtw_result_serializer.sv
// Bench for dtw_result_serializer: directed scenarios plus a randomized run
// checked against a round-robin / packetising reference model.
module tb_dtw_result_serializer;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [15:0]  batch_len = 16'd0;
  logic [3:0]   res_valid = 4'd0;
  logic [3:0]   res_ready;
  logic [127:0] res_minval = '0;
  logic [127:0] res_position = '0;
  logic [63:0]  res_qid = '0;
  logic         tvalid;
  logic [31:0]  tdata;
  logic [3:0]   tstrb;
  logic         tlast;
  logic         tready = 1'b0;
  logic         busy;
  logic [31:0]  results_sent;

  int vectors = 0;
  int miscompares = 0;
  int model_last = NC - 1;

  logic [3:0]   g_ready[$];
  logic [3:0]   g_valid[$];
  logic [127:0] g_min[$];
  logic [127:0] g_pos[$];
  logic [63:0]  g_qid[$];
  logic [32:0]  w_log[$];

  dtw_result_serializer #(.NUM_CORES(NC), .C_M_AXIS_TDATA_WIDTH(32), .QID_WIDTH(16)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(enable), .batch_len(batch_len),
    .res_valid(res_valid), .res_ready(res_ready), .res_minval(res_minval),
    .res_position(res_position), .res_qid(res_qid), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready), .busy(busy), .results_sent(results_sent));

  always #5 clk = ~clk;

  // Log grants (with the inputs seen at that moment) and stream handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_ready != 4'd0) begin
        g_ready.push_back(res_ready);
        g_valid.push_back(res_valid);
        g_min.push_back(res_minval);
        g_pos.push_back(res_position);
        g_qid.push_back(res_qid);
      end
      if (tvalid && tready) w_log.push_back({tlast, tdata});
    end
  end

  function automatic int rr_pick(int last, logic [3:0] v);
    for (int i = 1; i <= NC; i++) begin
      int c;
      c = (last + i) % NC;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_word(int k, int j, int core);
    if (j == 0) return {8'(core), 8'h00, g_qid[k][16*core +: 16]};
    if (j == 1) return g_min[k][32*core +: 32];
    return g_pos[k][32*core +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_ready.delete(); g_valid.delete(); g_min.delete();
    g_pos.delete(); g_qid.delete(); w_log.delete();
  endtask

  task automatic rand_data();
    for (int c = 0; c < NC; c++) begin
      res_minval[32*c +: 32]   = $urandom;
      res_position[32*c +: 32] = $urandom;
      res_qid[16*c +: 16]      = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    res_valid = 4'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_last = NC - 1;
    clear_logs();
  endtask

  task automatic wait_grants(int n, int budget);
    int t = 0;
    while (g_ready.size() < n && t < budget) begin tick(); t++; end
  endtask

  task automatic wait_words(int n, int budget);
    int t = 0;
    while (w_log.size() < n && t < budget) begin tick(); t++; end
  endtask

  task automatic test_reset();
    enable = 1'b1; res_valid = 4'hF; rst_n = 1'b0;
    #2;
    vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    vectors++; if (tdata !== 32'd0) begin miscompares++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
    vectors++; if (tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b expected 0", tlast); end
    vectors++; if (res_ready !== 4'd0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", res_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (results_sent !== 32'd0) begin miscompares++; $display("FAIL reset_sent: got %0d expected 0", results_sent); end
    vectors++; if (tstrb !== 4'hF) begin miscompares++; $display("FAIL reset_tstrb: got %h expected f", tstrb); end
    enable = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    logic [32:0] exp[3];
    exp[0] = {1'b0, 32'h02000005}; exp[1] = {1'b0, 32'h00000064}; exp[2] = {1'b1, 32'h00001234};
    batch_len = 16'd0; tready = 1'b1; enable = 1'b1;
    res_qid[32 +: 16] = 16'h0005; res_minval[64 +: 32] = 32'h64; res_position[64 +: 32] = 32'h1234;
    clear_logs();
    res_valid = 4'b0100;
    @(negedge clk);
    vectors++; if (res_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %b expected 0100", res_ready); end
    vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("FAIL single_idle_tvalid: got %b expected 0", tvalid); end
    tick();
    res_valid = 4'd0;
    @(negedge clk);
    vectors++; if (res_ready !== 4'd0) begin miscompares++; $display("FAIL single_ready_once: got %b expected 0000", res_ready); end
    vectors++; if (tvalid !== 1'b1 || tdata !== 32'h02000005) begin miscompares++; $display("FAIL single_latency: got tvalid=%b tdata=%h expected 1/02000005", tvalid, tdata); end
    tick();
    wait_words(3, 20);
    vectors++; if (w_log.size() != 3) begin miscompares++; $display("FAIL single_count: got %0d words expected 3", w_log.size()); end
    for (int j = 0; j < 3 && j < w_log.size(); j++) begin
      vectors++; if (w_log[j] !== exp[j]) begin miscompares++; $display("FAIL single_word%0d: got %h expected %h", j, w_log[j], exp[j]); end
    end
    vectors++; if (results_sent !== 32'd1) begin miscompares++; $display("FAIL single_sent: got %0d expected 1", results_sent); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b expected 0", busy); end
    model_last = 2;
  endtask

  task automatic test_fairness();
    do_reset();
    enable = 1'b1; tready = 1'b1; batch_len = 16'd0;
    rand_data();
    res_valid = 4'hF;
    wait_grants(8, 100);
    res_valid = 4'd0;
    wait_words(24, 60);
    vectors++; if (g_ready.size() != 8) begin miscompares++; $display("FAIL fair_grants: got %0d expected 8", g_ready.size()); end
    vectors++; if (w_log.size() != 24) begin miscompares++; $display("FAIL fair_words: got %0d expected 24", w_log.size()); end
    for (int k = 0; k < g_ready.size() && k < 8; k++) begin
      vectors++;
      if (g_ready[k] !== (4'b0001 << (k % NC))) begin miscompares++; $display("FAIL fair_order%0d: got %b expected %b", k, g_ready[k], 4'b0001 << (k % NC)); end
      for (int j = 0; j < 3 && 3*k+j < w_log.size(); j++) begin
        vectors++;
        if (w_log[3*k+j][31:0] !== exp_word(k, j, k % NC)) begin miscompares++; $display("FAIL fair_word%0d_%0d: got %h expected %h", k, j, w_log[3*k+j][31:0], exp_word(k, j, k % NC)); end
      end
    end
    model_last = 3;
  endtask

  task automatic test_backpressure();
    logic        have_held = 1'b0;
    logic [32:0] held = '0;
    int          t = 0;
    int          exp_core;
    rand_data();
    clear_logs();
    tready = 1'b0;
    res_valid = 4'b0010;
    while (t < 40 && !(w_log.size() >= 3 && !tvalid)) begin
      if (g_ready.size() > 0) res_valid = 4'd0;
      tready = ~tready;
      @(negedge clk);
      if (tvalid && have_held) begin
        vectors++;
        if ({tlast, tdata} !== held) begin miscompares++; $display("FAIL bp_hold: got %h expected %h", {tlast, tdata}, held); end
      end
      have_held = tvalid && !tready;
      held = {tlast, tdata};
      tick();
      t++;
    end
    exp_core = rr_pick(model_last, 4'b0010);
    vectors++; if (w_log.size() != 3) begin miscompares++; $display("FAIL bp_count: got %0d expected 3", w_log.size()); end
    vectors++; if (g_ready.size() != 1) begin miscompares++; $display("FAIL bp_grants: got %0d expected 1", g_ready.size()); end
    for (int j = 0; j < 3 && j < w_log.size() && g_ready.size() > 0; j++) begin
      vectors++;
      if (w_log[j][31:0] !== exp_word(0, j, exp_core)) begin miscompares++; $display("FAIL bp_word%0d: got %h expected %h", j, w_log[j][31:0], exp_word(0, j, exp_core)); end
    end
    tready = 1'b1;
    model_last = exp_core;
  endtask

  task automatic test_batching();
    int cnt = 0;
    int bl;
    logic tl;
    tready = 1'b1; enable = 1'b1; batch_len = 16'd3;
    rand_data();
    clear_logs();
    res_valid = 4'b1000;
    wait_grants(7, 100);
    res_valid = 4'd0;
    wait_words(21, 40);
    batch_len = 16'd1;
    res_valid = 4'b1000;
    wait_grants(8, 20);
    res_valid = 4'd0;
    wait_words(24, 40);
    vectors++; if (w_log.size() != 24) begin miscompares++; $display("FAIL batch_words: got %0d expected 24", w_log.size()); end
    for (int r = 0; r < 8 && 3*r+2 < w_log.size(); r++) begin
      bl = (r < 7) ? 3 : 1;
      tl = (cnt + 1 >= bl);
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (w_log[3*r+j][32] !== ((j == 2) ? tl : 1'b0)) begin miscompares++; $display("FAIL batch_tlast r%0d w%0d: got %b expected %b", r+1, j, w_log[3*r+j][32], (j == 2) ? tl : 1'b0); end
      end
      cnt = tl ? 0 : cnt + 1;
    end
    model_last = 3;
  endtask

  task automatic test_enable();
    batch_len = 16'd2; tready = 1'b1; enable = 1'b1;
    rand_data();
    clear_logs();
    res_valid = 4'b0001;
    wait_grants(1, 20);
    res_valid = 4'd0;
    wait_words(3, 20);
    enable = 1'b0;
    res_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (res_ready !== 4'd0 || tvalid !== 1'b0) begin miscompares++; $display("FAIL en_block c%0d: got ready=%b tvalid=%b expected 0000/0", c, res_ready, tvalid); end
      tick();
    end
    enable = 1'b1;
    @(negedge clk);
    vectors++; if (res_ready !== 4'b0010) begin miscompares++; $display("FAIL en_grant: got %b expected 0010", res_ready); end
    tick();
    res_valid = 4'd0;
    wait_words(6, 20);
    vectors++; if (w_log.size() != 6) begin miscompares++; $display("FAIL en_words: got %0d expected 6", w_log.size()); end
    if (w_log.size() >= 6) begin
      vectors++; if (w_log[2][32] !== 1'b0) begin miscompares++; $display("FAIL en_first_tlast: got %b expected 0", w_log[2][32]); end
      vectors++; if (w_log[5][32] !== 1'b0) begin miscompares++; $display("FAIL en_cnt_clear: got tlast %b expected 0", w_log[5][32]); end
      vectors++; if (w_log[3][31:0] !== exp_word(1, 0, 1)) begin miscompares++; $display("FAIL en_hdr: got %h expected %h", w_log[3][31:0], exp_word(1, 0, 1)); end
    end
    model_last = 1;
  endtask

  task automatic test_reset_mid();
    batch_len = 16'd0; tready = 1'b1; enable = 1'b1;
    rand_data();
    clear_logs();
    res_valid = 4'b0100;
    wait_grants(1, 20);
    res_valid = 4'd0;
    wait_words(2, 20);
    vectors++; if (tvalid !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: got tvalid %b expected 1", tvalid); end
    rst_n = 1'b0;
    #1;
    vectors++; if (tvalid !== 1'b0 || tdata !== 32'd0 || tlast !== 1'b0) begin miscompares++; $display("FAIL rmid_outputs: got %b/%h/%b expected 0/0/0", tvalid, tdata, tlast); end
    vectors++; if (busy !== 1'b0 || results_sent !== 32'd0) begin miscompares++; $display("FAIL rmid_state: got busy=%b sent=%0d expected 0/0", busy, results_sent); end
    tick();
    rst_n = 1'b1;
    clear_logs();
    model_last = NC - 1;
    res_valid = 4'b0101;
    wait_grants(1, 20);
    res_valid = 4'd0;
    wait_words(3, 20);
    vectors++; if (g_ready.size() < 1 || g_ready[0] !== 4'b0001) begin miscompares++; $display("FAIL rmid_prio: got %b expected 0001", (g_ready.size() > 0) ? g_ready[0] : 4'd0); end
    vectors++; if (w_log.size() != 3) begin miscompares++; $display("FAIL rmid_words: got %0d expected 3", w_log.size()); end
    for (int j = 0; j < 3 && j < w_log.size() && g_ready.size() > 0; j++) begin
      vectors++;
      if (w_log[j][31:0] !== exp_word(0, j, 0)) begin miscompares++; $display("FAIL rmid_word%0d: got %h expected %h", j, w_log[j][31:0], exp_word(0, j, 0)); end
    end
    vectors++; if (results_sent !== 32'd1) begin miscompares++; $display("FAIL rmid_sent: got %0d expected 1", results_sent); end
  endtask

  task automatic test_random();
    int bl, last, cnt, exp_core, t;
    logic tl;
    do_reset();
    enable = 1'b1;
    bl = $urandom_range(0, 4);
    batch_len = 16'(bl);
    for (int c = 0; c < 600; c++) begin
      res_valid = 4'($urandom);
      rand_data();
      tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    res_valid = 4'd0;
    tready = 1'b1;
    t = 0;
    while (busy && t < 20) begin tick(); t++; end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rnd_drain: got busy %b expected 0", busy); end
    vectors++; if (w_log.size() != 3*g_ready.size()) begin miscompares++; $display("FAIL rnd_words: got %0d expected %0d", w_log.size(), 3*g_ready.size()); end
    vectors++; if (results_sent !== 32'(g_ready.size())) begin miscompares++; $display("FAIL rnd_sent: got %0d expected %0d", results_sent, g_ready.size()); end
    last = NC - 1;
    cnt = 0;
    for (int k = 0; k < g_ready.size() && 3*k+2 < w_log.size(); k++) begin
      exp_core = rr_pick(last, g_valid[k]);
      vectors++;
      if (exp_core < 0 || g_ready[k] !== (4'b0001 << exp_core)) begin miscompares++; $display("FAIL rnd_grant%0d: got %b expected core %0d", k, g_ready[k], exp_core); end
      if (exp_core >= 0) last = exp_core;
      tl = (bl == 0) || (cnt + 1 >= bl);
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (w_log[3*k+j] !== {(j == 2) ? tl : 1'b0, exp_word(k, j, last)}) begin
          miscompares++;
          $display("FAIL rnd_word%0d_%0d: got %h expected %h", k, j, w_log[3*k+j], {(j == 2) ? tl : 1'b0, exp_word(k, j, last)});
        end
      end
      cnt = tl ? 0 : cnt + 1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_batching();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dtw_result_serializer.md
DTW_RESULT_SERIALIZER -- requirements
Module: dtw_result_serializer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of dtw_core result ports (1..16).
REQ-002 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, output stream width (only 32 supported).
REQ-003 SHALL have parameter QID_WIDTH, default 16, query-id width (<=16).
REQ-004 SHALL have port M_AXIS_ACLK  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port M_AXIS_ARESETN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  permits new result grants.
REQ-007 SHALL have port batch_len  input  16  results per stream packet; 0 = one result per packet.
REQ-008 SHALL have port res_valid  input  NUM_CORES  per-core result available.
REQ-009 SHALL have port res_ready  output  NUM_CORES  per-core capture strobe.
REQ-010 SHALL have port res_minval  input  32*NUM_CORES  per-core minimum DTW cost, core i at [32*i+:32].
REQ-011 SHALL have port res_position  input  32*NUM_CORES  per-core match position.
REQ-012 SHALL have port res_qid  input  QID_WIDTH*NUM_CORES  per-core query id.
REQ-013 SHALL have ports M_AXIS_TVALID out 1, M_AXIS_TDATA out 32, M_AXIS_TSTRB out 4, M_AXIS_TLAST out 1, M_AXIS_TREADY in 1.
REQ-014 SHALL have port busy  output  1  result captured and not yet fully sent.
REQ-015 SHALL have port results_sent  output  32  count of completely transmitted results.

Function
REQ-016 SHALL implement FSM states IDLE, W0, W1, W2.
REQ-017 In IDLE with enable=1 and res_valid!=0, SHALL grant one core by round-robin, search starting at (last_grant+1) mod NUM_CORES; last_grant resets to NUM_CORES-1 (core 0 first).
REQ-018 res_ready SHALL be combinational, one-hot, asserted only in IDLE for the granted core; capture of minval/position/qid/core index occurs on that edge; state -> W0.
REQ-019 Word order SHALL be W0={core_idx[7:0], 8'h00, qid zero-extended to 16}, W1=minval, W2=position.
REQ-020 M_AXIS_TVALID SHALL be 1 exactly in W0/W1/W2; state advances W0->W1->W2->IDLE only on TVALID&TREADY.
REQ-021 TDATA/TLAST SHALL hold stable while TVALID=1 and TREADY=0; TSTRB SHALL be 4'hF constantly.
REQ-022 Latency: res_valid seen in IDLE at cycle t -> TVALID=1 with W0 at t+1; full result minimum 4 cycles (1 idle bubble).
REQ-023 Batch counter SHALL count results in current packet; TLAST=1 only in W2 when batch_len=0 or counter==batch_len-1; counter clears after that word, else increments on W2 handshake.
REQ-024 batch_len SHALL be sampled at each W2 handshake; lowering it below the counter SHALL close the packet on the next W2.
REQ-025 enable=0 SHALL block new grants only; an in-flight result SHALL complete; batch counter SHALL clear while enable=0 and state=IDLE.
REQ-026 res_valid dropping while not granted SHALL be ignored (no capture, no state change).
REQ-027 results_sent SHALL increment on each W2 handshake, wrapping 0xFFFFFFFF->0.
REQ-028 busy SHALL equal (state!=IDLE).

Reset
REQ-029 ARESETN=0 SHALL immediately force state IDLE, TVALID=0, TLAST=0, TDATA=0, res_ready=0, busy=0, results_sent=0, batch counter=0, last_grant=NUM_CORES-1, regardless of in-flight transfer.
REQ-030 A result interrupted by reset SHALL be discarded, not resumed.

Verification
REQ-031 Single result: core 2 valid, qid=0x0005, minval=0x64, position=0x1234, batch_len=0, TREADY=1 -> res_ready=4'b0100 one cycle; words 0x02000005, 0x00000064, 0x00001234; TLAST only on third; results_sent=1.
REQ-032 Fairness: all 4 cores valid continuously, 8 results -> grant order 0,1,2,3,0,1,2,3.
REQ-033 Backpressure: TREADY toggled 1/0 each cycle during a result -> each word held unchanged while TREADY=0; 3 handshakes, no word duplicated or lost.
REQ-034 Batching: batch_len=3, 7 results -> TLAST on W2 of results 3 and 6 only; result 7 W2 TLAST=0.
REQ-035 Reset mid-result: assert ARESETN=0 after W1 handshake -> TVALID=0 same cycle; after release, next valid result streams from W0 with core 0 priority.
REQ-036 Enable: enable=0 with core 1 valid -> no res_ready, TVALID=0 for 20 cycles; enable=1 -> grant core 1 next cycle.
